uart_tx_arbiter: RTL and testbench

- Shares one uart_transmitter between NUM_REQ byte producers using round-robin arbitration.
- Latches the winner's byte and drives the transmitter's transmit/data inputs.
- Tracks the transmitter's busy flag through the full frame, then returns a one-cycle ack to the winner.
- Sits between the protocol/command blocks and the uart_transmitter instance.

---
 rtl/uart_tx_arbiter_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_rr_priority_picker.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and limits for the UART transmit arbiter.
// Optional busy-rise watchdog is enabled with UART_TX_ARB_TIMEOUT_EN (see top).
package uart_tx_arbiter_pkg;

  typedef logic       bit_t;
  typedef logic [7:0] uint8_t;

  localparam int MAX_NUM_REQ = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    ACK
  } arb_state_t;

  // Index width that stays at least one bit wide for tiny requester counts.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: scans from ptr_i upward (wrapping) and
// returns the first set request as one-hot plus index.
module rr_priority_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] winner_oh_o,
  output logic [IDX_W-1:0]   winner_idx_o,
  output bit_t               valid_o
);

  logic [NUM_REQ-1:0] hit;
  logic [IDX_W-1:0]   cand [NUM_REQ];

  // cand[gi] is the requester examined at scan position gi.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum       = {1'b0, ptr_i} + (IDX_W+1)'(gi);
    assign cand[gi]  = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                    : sum[IDX_W-1:0];
    assign hit[gi]   = req_i[cand[gi]];
  end

  always_comb begin
    valid_o      = 1'b0;
    winner_idx_o = '0;
    winner_oh_o  = '0;
    // Walk backwards so the earliest scan position is the last to write.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        valid_o      = 1'b1;
        winner_idx_o = cand[i];
      end
    end
    if (valid_o) winner_oh_o[winner_idx_o] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ producers.
// Define UART_TX_ARB_TIMEOUT_EN to add the busy-rise watchdog and err pulse.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  uint8_t [NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  tx_transmit,
  output uint8_t                tx_data,
  input  logic                  tx_busy,
  output logic                  err
);

  localparam int IDX_W  = idx_width(NUM_REQ);
  localparam int PCNT_W = (PULSE_CYCLES < 2) ? 1 : $clog2(PULSE_CYCLES);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ || PULSE_CYCLES < 1 || TIMEOUT_CYCLES < 1)
  begin : g_bad_params
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  uint8_t              data_q, data_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  bit_t                seen_q, seen_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  bit_t                pick_valid;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .winner_oh_o  (pick_oh),
    .winner_idx_o (pick_idx),
    .valid_o      (pick_valid)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  bit_t            err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    data_d  = data_q;
    pcnt_d  = pcnt_q;
    seen_d  = seen_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!tx_busy && pick_valid) begin
          grant_d = pick_oh;
          idx_d   = pick_idx;
          data_d  = req_data[pick_idx];
          pcnt_d  = '0;
          seen_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        // Remember a busy rise during the pulse so WAIT_BUSY cannot miss a short frame.
        seen_d = seen_q | tx_busy;
        if (pcnt_q == PCNT_W'(PULSE_CYCLES - 1)) begin
          pcnt_d  = '0;
          state_d = WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy || seen_q) begin
          state_d = WAIT_DONE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ACK;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = ACK;
      end
      ACK: begin
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        grant_d = '0;
        data_d  = '0;
        state_d = IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      pcnt_q  <= '0;
      seen_q  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      pcnt_q  <= pcnt_d;
      seen_q  <= seen_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign tx_data     = data_q;
  assign tx_transmit = (state_q == START);
  assign ack         = (state_q == ACK) ? grant_q : '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter busy model.
// Covers UART_TX_ARB_TIMEOUT_EN in both builds (watchdog test switches on it).
module tb_uart_tx_arbiter;

  localparam int FRAME = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req;
  logic [3:0][7:0]  req_data;
  logic [3:0]       ack;
  logic [3:0]       grant;
  logic             tx_transmit;
  logic [7:0]       tx_data;
  logic             tx_busy = 1'b0;
  logic             err;

  bit model_en = 1'b1;
  int frame_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4), .PULSE_CYCLES(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .grant(grant), .tx_transmit(tx_transmit), .tx_data(tx_data),
    .tx_busy(tx_busy), .err(err)
  );

  // Transmitter model: a transmit seen while idle starts a FRAME-cycle busy period.
  always @(posedge clk) begin
    if (model_en) begin
      if (frame_cnt > 0) begin
        frame_cnt <= frame_cnt - 1;
        if (frame_cnt == 1) tx_busy <= 1'b0;
      end else if (tx_transmit && !tx_busy) begin
        tx_busy   <= 1'b1;
        frame_cnt <= FRAME;
      end
    end
  end

  typedef struct {
    logic [3:0] set_mask;
    int         exp_idx;
    logic [7:0] exp_byte;
    bit         drop_early;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input int t, input logic [3:0] set_mask, input int exp_idx,
                         input logic [7:0] exp_byte, input bit drop_early);
    logic [3:0] oh;
    logic [7:0] orig;
    int n;
    int pulse;
    bit stable;
    logic p1, p2;
    oh   = 4'b0001 << exp_idx;
    orig = req_data[exp_idx];
    req  = req | set_mask;
    n = 0;
    @(negedge clk);
    while (grant == 4'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("t%0d grant", t), 32'(grant), 32'(oh));
    check($sformatf("t%0d tx_data", t), 32'(tx_data), 32'(exp_byte));
    if (drop_early) begin
      req[exp_idx]      = 1'b0;
      req_data[exp_idx] = 8'hFF;
    end
    pulse = 0;
    while (tx_transmit && pulse < 50) begin
      pulse++;
      @(negedge clk);
    end
    check($sformatf("t%0d pulse_len", t), 32'(pulse), 32'd2);
    stable = 1'b1;
    p1 = 1'b0;
    p2 = 1'b0;
    n = 0;
    while (ack == 4'b0 && n < 200) begin
      if (tx_data !== exp_byte || grant !== oh) stable = 1'b0;
      p2 = p1;
      p1 = tx_busy;
      @(negedge clk);
      n++;
    end
    check($sformatf("t%0d ack", t), 32'(ack), 32'(oh));
    check($sformatf("t%0d data_stable", t), 32'(stable), 32'd1);
    check($sformatf("t%0d ack_after_busy_fall", t), 32'({p2, p1}), 32'b10);
    req[exp_idx]      = 1'b0;
    req_data[exp_idx] = orig;
    @(negedge clk);
    check($sformatf("t%0d post_ack", t), 32'({ack, grant, tx_data}), 32'd0);
  endtask

  initial begin
    int n;
    bit bad;
    vecs[0]  = '{4'b1111, 0, 8'h11, 1'b0};
    vecs[1]  = '{4'b0000, 1, 8'h5A, 1'b0};
    vecs[2]  = '{4'b0000, 2, 8'h22, 1'b0};
    vecs[3]  = '{4'b0000, 3, 8'h33, 1'b0};
    vecs[4]  = '{4'b0001, 0, 8'h11, 1'b0};
    vecs[5]  = '{4'b0010, 1, 8'h5A, 1'b0};
    vecs[6]  = '{4'b0100, 2, 8'h22, 1'b0};
    vecs[7]  = '{4'b0101, 0, 8'h11, 1'b0};
    vecs[8]  = '{4'b0000, 2, 8'h22, 1'b0};
    vecs[9]  = '{4'b1000, 3, 8'h33, 1'b1};
    vecs[10] = '{4'b1010, 1, 8'h5A, 1'b0};
    vecs[11] = '{4'b0000, 3, 8'h33, 1'b0};
    vecs[12] = '{4'b0010, 1, 8'h5A, 1'b0};

    reset    = 1'b1;
    req      = 4'b0;
    req_data = {8'h33, 8'h22, 8'h5A, 8'h11};
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({ack, grant, tx_transmit, tx_data, err}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_grant", 32'(grant), 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_txn(i, vecs[i].set_mask, vecs[i].exp_idx, vecs[i].exp_byte, vecs[i].drop_early);
      $display("txn %0d: req_set=%b winner=%0d byte=%h", i, vecs[i].set_mask,
               vecs[i].exp_idx, vecs[i].exp_byte);
    end

    // Reset during WAIT_DONE: pointer (now 2) must return to 0, no ack.
    req = 4'b0100;
    n = 0;
    @(negedge clk);
    while (grant == 4'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid grant", 32'(grant), 32'b0100);
    n = 0;
    while (tx_transmit && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("rst_mid busy_before_reset", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid outputs", 32'({ack, grant, tx_transmit, tx_data}), 32'd0);
    req = 4'b0101;
    bad = 1'b0;
    n = 0;
    while (tx_busy && n < 200) begin
      if (grant != 4'b0 || ack != 4'b0) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check("rst_mid wait_for_idle_tx", 32'(bad), 32'd0);
    run_txn(20, 4'b0000, 0, 8'h11, 1'b0);
    $display("txn 20: after reset winner=0 byte=11");
    run_txn(21, 4'b0000, 2, 8'h22, 1'b0);
    $display("txn 21: after reset winner=2 byte=22");

    // Watchdog: transmitter never raises busy.
    model_en = 1'b0;
    req = 4'b0001;
    n = 0;
    @(negedge clk);
    while (grant == 4'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to grant", 32'(grant), 32'b0001);
    n = 0;
    while (tx_transmit && n < 50) begin
      @(negedge clk);
      n++;
    end
    bad = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    n = 0;
    while (ack == 4'b0 && n < 100) begin
      if (err) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check("to latency", 32'(n), 32'd8);
    check("to ack", 32'(ack), 32'b0001);
    check("to err", 32'(err), 32'd1);
    check("to err_early", 32'(bad), 32'd0);
    req = 4'b0;
    @(negedge clk);
    check("to err_one_cycle", 32'(err), 32'd0);
    $display("txn 22: watchdog ack+err after %0d cycles", n);
`else
    for (int i = 0; i < 60; i++) begin
      if (ack != 4'b0 || err) bad = 1'b1;
      @(negedge clk);
    end
    check("to no_ack_no_err", 32'(bad), 32'd0);
    check("to still_granted", 32'(grant), 32'b0001);
    check("to no_transmit", 32'(tx_transmit), 32'd0);
    req = 4'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("txn 22: no watchdog, stayed in WAIT_BUSY");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
